// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 adder front end: alignment FSM states and
// field widths used by fp_mant_align and its helpers.
package fp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } fsm_state_t;

   localparam int GRS_W = 3;
   localparam int EXP_W = 8;

endpackage

// File: rtl/CLA8bit.sv
// 8-bit carry-lookahead adder cell; each carry is formed from the generate and
// propagate terms below it rather than rippling through the sum logic.
module CLA8bit (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_ci,
   output logic [7:0] o_s,
   output logic       o_co
);

   logic [7:0] w_g;
   logic [7:0] w_p;
   logic [8:0] w_c;

   function automatic logic carry_into(input int k, input logic [7:0] g,
                                       input logic [7:0] p, input logic ci);
      logic acc;
      acc = ci;
      for (int j = 0; j < k; j++)
         acc = g[j] | (p[j] & acc);
      return acc;
   endfunction

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   for (genvar k = 0; k <= 8; k++) begin : g_carry
      assign w_c[k] = carry_into(k, w_g, w_p, i_ci);
   end

   assign o_s  = w_p ^ w_c[7:0];
   assign o_co = w_c[8];

endmodule

// File: rtl/fp_sticky_shr.sv
// Combinational right shift by 0..STEP; every bit that leaves, plus the old
// sticky in bit 0, is OR-folded into the new bit 0.
module fp_sticky_shr #(
   parameter  int W    = 27,
   parameter  int STEP = 4,
   localparam int SH_W = $clog2(STEP + 1)
) (
   input  logic [W-1:0]    i_data,
   input  logic [SH_W-1:0] i_sh,
   output logic [W-1:0]    o_data
);

   logic w_sticky;

   always_comb begin
      w_sticky = 1'b0;
      for (int k = 0; k <= STEP; k++)
         if (k <= int'(i_sh))
            w_sticky = w_sticky | i_data[k];
   end

   // The shifted bit 0 is i_data[i_sh], already part of w_sticky, so OR is exact.
   assign o_data = (i_data >> i_sh) | {{(W-1){1'b0}}, w_sticky};

endmodule

// File: rtl/fp_mant_align.sv
// Iterative FP32 mantissa alignment: picks the larger-exponent operand and
// right-shifts the smaller mantissa STEP bits per cycle with guard/round/sticky.
// Optional macro FP_ALIGN_FASTPATH_EN: shifts of MANT_W+2 or more skip SHIFT.
//
// state    | meaning
// ST_IDLE  | in_ready high, waiting for an operand pair
// ST_SHIFT | shifting the smaller mantissa, r_rem bits still to go
// ST_DONE  | out_valid high, outputs held until out_ready
module fp_mant_align
   import fp_pkg::*;
#(
   parameter int MANT_W = 24,
   parameter int STEP   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W-1:0]        exp_a,
   input  logic [EXP_W-1:0]        exp_b,
   input  logic [MANT_W-1:0]       mant_a,
   input  logic [MANT_W-1:0]       mant_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W-1:0]        exp_out,
   output logic                    swap,
   output logic [MANT_W-1:0]       mant_big,
   output logic [MANT_W+GRS_W-1:0] mant_small
);

   localparam int SR_W   = MANT_W + GRS_W;
   localparam int MAX_SH = MANT_W + 2;
   localparam int REM_W  = $clog2(MAX_SH + 1);
   localparam int SH_W   = $clog2(STEP + 1);

   fsm_state_t        r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_swap;
   logic [EXP_W-1:0]  r_exp;
   logic [MANT_W-1:0] r_big;
   logic [SR_W-1:0]   r_shreg;
   logic [REM_W-1:0]  r_rem;

   logic [EXP_W-1:0]  w_diff;
   logic [EXP_W-1:0]  w_d;
   logic              w_a_ge_b;
   logic              w_far;
   logic [REM_W-1:0]  w_d_eff;
   logic [MANT_W-1:0] w_small_in;
   logic [MANT_W-1:0] w_big_in;
   logic [SH_W-1:0]   w_step;
   logic [SR_W-1:0]   w_shifted;

   // exp_a + ~exp_b + 1: carry out means exp_a >= exp_b
   CLA8bit u_cla (
      .i_a  (exp_a),
      .i_b  (~exp_b),
      .i_ci (1'b1),
      .o_s  (w_diff),
      .o_co (w_a_ge_b)
   );

   assign w_d        = w_a_ge_b ? w_diff : (~w_diff + EXP_W'(1));
   assign w_far      = (w_d >= EXP_W'(MAX_SH));
   assign w_d_eff    = w_far ? REM_W'(MAX_SH) : REM_W'(w_d);
   assign w_small_in = w_a_ge_b ? mant_b : mant_a;
   assign w_big_in   = w_a_ge_b ? mant_a : mant_b;
   assign w_step     = (r_rem > REM_W'(STEP)) ? SH_W'(STEP) : SH_W'(r_rem);

   fp_sticky_shr #(
      .W    (SR_W),
      .STEP (STEP)
   ) u_shr (
      .i_data (r_shreg),
      .i_sh   (w_step),
      .o_data (w_shifted)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_swap      <= 1'b0;
         r_exp       <= '0;
         r_big       <= '0;
         r_shreg     <= '0;
         r_rem       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_exp      <= w_a_ge_b ? exp_a : exp_b;
                  r_swap     <= ~w_a_ge_b;
                  r_big      <= w_big_in;
                  r_in_ready <= 1'b0;
`ifdef FP_ALIGN_FASTPATH_EN
                  if (w_far) begin
                     r_shreg     <= {{(SR_W-1){1'b0}}, |w_small_in};
                     r_rem       <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else
`endif
                  begin
                     r_shreg <= {w_small_in, {GRS_W{1'b0}}};
                     r_rem   <= w_d_eff;
                     if (w_d_eff == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                     end else begin
                        r_state <= ST_SHIFT;
                     end
                  end
               end
            end
            ST_SHIFT: begin
               r_shreg <= w_shifted;
               r_rem   <= r_rem - REM_W'(w_step);
               if (r_rem == REM_W'(w_step)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign exp_out    = r_exp;
   assign swap       = r_swap;
   assign mant_big   = r_big;
   assign mant_small = r_shreg;

endmodule

// File: tb/tb_fp_mant_align.sv
// Self-checking bench for fp_mant_align: directed plan vectors, random operands
// against an arithmetic reference, backpressure, mid-shift reset, throughput.
module tb_fp_mant_align;

   localparam int MANT_W = 24;
   localparam int STEP   = 4;
   localparam int MAX_SH = MANT_W + 2;
   localparam int BOUND  = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  exp_a, exp_b;
   logic [23:0] mant_a, mant_b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  exp_out;
   logic        swap;
   logic [23:0] mant_big;
   logic [26:0] mant_small;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fp_mant_align #(.MANT_W(MANT_W), .STEP(STEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .exp_a      (exp_a),
      .exp_b      (exp_b),
      .mant_a     (mant_a),
      .mant_b     (mant_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .exp_out    (exp_out),
      .swap       (swap),
      .mant_big   (mant_big),
      .mant_small (mant_small)
   );

   wire [59:0] obs = {swap, exp_out, mant_big, mant_small};

   // in_ready and out_valid must never be high together
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         n_checks++;
         if (in_ready === 1'b1 && out_valid === 1'b1) begin
            n_fail++;
            $display("FAIL ready_valid_exclusive: in_ready=%b out_valid=%b at %0t", in_ready, out_valid, $time);
         end
      end
   end

   // Reference: align by plain arithmetic; sticky = OR of all bits at or below the shift amount.
   function automatic void model(input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb,
                                 output logic [59:0] res, output int lat);
      int d, deff;
      logic sw, st;
      logic [7:0] eo;
      logic [23:0] big;
      logic [26:0] init, sm;
      if (ea >= eb) begin
         sw = 1'b0; d = int'(ea) - int'(eb); eo = ea; big = ma; init = {mb, 3'b000};
      end else begin
         sw = 1'b1; d = int'(eb) - int'(ea); eo = eb; big = mb; init = {ma, 3'b000};
      end
      deff = (d > MAX_SH) ? MAX_SH : d;
      sm = init >> deff;
      st = 1'b0;
      for (int i = 0; i <= deff; i++) st = st | init[i];
      sm[0] = st;
      lat = 1 + (deff + STEP - 1) / STEP;
`ifdef FP_ALIGN_FASTPATH_EN
      if (d >= MAX_SH) lat = 1;
`endif
      res = {sw, eo, big, sm};
   endfunction

   task automatic drive_op(input logic [7:0] ea, input logic [7:0] eb,
                           input logic [23:0] ma, input logic [23:0] mb,
                           output int lat, output logic timeout);
      @(negedge clk);
      exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < BOUND) begin
         @(posedge clk);
         #1;
         lat++;
      end
      timeout = (out_valid !== 1'b1);
   endtask

   task automatic release_op;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, obs} !== 61'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", {out_valid, obs});
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [7:0]  t_ea [4] = '{8'd130, 8'd100, 8'd127, 8'd200};
   logic [7:0]  t_eb [4] = '{8'd127, 8'd105, 8'd127, 8'd10};
   logic [23:0] t_ma [4] = '{24'hC00000, 24'h800001, 24'h800000, 24'h900000};
   logic [23:0] t_mb [4] = '{24'h800000, 24'hA00000, 24'hFFFFFF, 24'h800000};
   logic [59:0] t_res[4] = '{{1'b0, 8'd130, 24'hC00000, 27'h0800000},
                             {1'b1, 8'd105, 24'hA00000, 27'h0200001},
                             {1'b0, 8'd127, 24'h800000, 27'h7FFFFF8},
                             {1'b0, 8'd200, 24'h900000, 27'h0000001}};
`ifdef FP_ALIGN_FASTPATH_EN
   int t_lat[4] = '{2, 3, 1, 1};
`else
   int t_lat[4] = '{2, 3, 1, 8};
`endif

   task automatic test_directed;
      int lat;
      logic to;
      for (int i = 0; i < 4; i++) begin
         drive_op(t_ea[i], t_eb[i], t_ma[i], t_mb[i], lat, to);
         n_checks++;
         if (to) begin
            n_fail++;
            $display("FAIL directed_timeout[%0d]: out_valid not seen in %0d cycles", i, BOUND);
         end
         n_checks++;
         if (obs !== t_res[i]) begin
            n_fail++;
            $display("FAIL directed_result[%0d]: got %h expected %h", i, obs, t_res[i]);
         end
         n_checks++;
         if (lat !== t_lat[i]) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, t_lat[i]);
         end
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_busy[%0d]: in_ready got %b expected 0", i, in_ready);
         end
         release_op();
         n_checks++;
         if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL directed_return_idle[%0d]: ready,valid got %b expected 10", i, {in_ready, out_valid});
         end
      end
   endtask

   task automatic test_random;
      int lat, elat, e;
      logic to;
      logic [7:0] ea, eb;
      logic [23:0] ma, mb;
      logic [59:0] eres;
      for (int i = 0; i < 40; i++) begin
         ea = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            e = int'(ea) + int'($urandom_range(0, 64)) - 32;
            if (e < 0) e = 0;
            if (e > 255) e = 255;
            eb = 8'(e);
         end else begin
            eb = 8'($urandom_range(0, 255));
         end
         ma = {1'b1, 23'($urandom)};
         mb = ($urandom_range(0, 7) == 0) ? 24'($urandom) : {1'b1, 23'($urandom)};
         model(ea, eb, ma, mb, eres, elat);
         drive_op(ea, eb, ma, mb, lat, to);
         n_checks++;
         if (to || obs !== eres) begin
            n_fail++;
            $display("FAIL random_result[%0d] ea=%0d eb=%0d: got %h expected %h timeout=%b", i, ea, eb, obs, eres, to);
         end
         n_checks++;
         if (lat !== elat) begin
            n_fail++;
            $display("FAIL random_latency[%0d] ea=%0d eb=%0d: got %0d expected %0d", i, ea, eb, lat, elat);
         end
         release_op();
      end
   endtask

   task automatic test_backpressure;
      int lat, elat, elat2;
      logic to;
      logic [59:0] eres, eres2;
      model(8'd130, 8'd127, 24'hC00000, 24'h800000, eres, elat);
      model(8'd10, 8'd200, 24'h812345, 24'hF00000, eres2, elat2);
      drive_op(8'd130, 8'd127, 24'hC00000, 24'h800000, lat, to);
      // offer a second pair while the first is stalled in DONE
      @(negedge clk);
      exp_a = 8'd10; exp_b = 8'd200; mant_a = 24'h812345; mant_b = 24'hF00000; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({out_valid, in_ready, obs} !== {2'b10, eres}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got %h expected %h", c, {out_valid, in_ready, obs}, {2'b10, eres});
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_handshake: ready,valid got %b expected 10", {in_ready, out_valid});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_next_accept: in_ready got %b expected 0", in_ready);
      end
      lat = 1;
      while (out_valid !== 1'b1 && lat < BOUND) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_checks++;
      if (out_valid !== 1'b1 || obs !== eres2 || lat !== elat2) begin
         n_fail++;
         $display("FAIL stall_second_op: got %h lat %0d expected %h lat %0d", obs, lat, eres2, elat2);
      end
      release_op();
   endtask

   task automatic test_reset_midshift;
      int lat, elat;
      logic to;
      logic [59:0] eres;
      @(negedge clk);
      exp_a = 8'd147; exp_b = 8'd127; mant_a = 24'hABCDEF; mant_b = 24'hFEDCBA; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL midshift_busy: ready,valid got %b expected 00", {in_ready, out_valid});
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, out_valid, obs} !== {2'b10, 60'd0}) begin
         n_fail++;
         $display("FAIL midshift_reset: got %h expected %h", {in_ready, out_valid, obs}, {2'b10, 60'd0});
      end
      @(negedge clk);
      rst = 1'b0;
      model(8'd90, 8'd101, 24'hC3A5F1, 24'h8F0F0F, eres, elat);
      drive_op(8'd90, 8'd101, 24'hC3A5F1, 24'h8F0F0F, lat, to);
      n_checks++;
      if (to || obs !== eres || lat !== elat) begin
         n_fail++;
         $display("FAIL after_reset_op: got %h lat %0d expected %h lat %0d", obs, lat, eres, elat);
      end
      release_op();
   endtask

   task automatic test_back_to_back;
      int lat, elat;
      logic to;
      logic [7:0] ea, eb;
      logic [23:0] ma, mb;
      logic [59:0] eres;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ea = 8'($urandom_range(100, 140));
         eb = (i % 2 == 0) ? ea : 8'($urandom_range(100, 140));
         ma = {1'b1, 23'($urandom)};
         mb = {1'b1, 23'($urandom)};
         model(ea, eb, ma, mb, eres, elat);
         drive_op(ea, eb, ma, mb, lat, to);
         n_checks++;
         if (to || obs !== eres || lat !== elat) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got %h lat %0d expected %h lat %0d", i, obs, lat, eres, elat);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d]: ready,valid got %b expected 10", i, {in_ready, out_valid});
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_midshift();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_mant_align.md
# fp_mant_align

Iterative mantissa-alignment stage of the FP32 adder datapath. It accepts two unpacked operands (8-bit biased exponents, 24-bit mantissas with the hidden bit explicit) and selects the larger-exponent operand. It then right-shifts the smaller mantissa by the exponent difference, a bounded number of bits per cycle, and keeps guard/round/sticky bits. Its output feeds the mantissa adder built from the team's carry-lookahead adder cells; its exponent difference is computed with CLA8bit.

## Interface
- MANT_W, 24: mantissa width including hidden bit.
- STEP, 4: maximum right-shift per SHIFT cycle; power of two, 1..16.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- exp_a, exp_b  in  8  biased exponents.
- mant_a, mant_b  in  MANT_W  mantissas.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts.
- exp_out  out  8  larger exponent.
- swap  out  1  1 = operand b is the larger operand.
- mant_big  out  MANT_W  unshifted larger-operand mantissa.
- mant_small  out  MANT_W+3  aligned smaller mantissa: bits [MANT_W+2:3] mantissa, [2] guard, [1] round, [0] sticky.

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset state is IDLE. Reset value of every output is 0, except in_ready = 1.
- Accept occurs when in_valid && in_ready at a clock edge.
- On accept, compute diff = exp_a − exp_b as 9-bit (CLA8bit: A=exp_a, B=~exp_b, Ci=1; Co=1 means exp_a ≥ exp_b).
  - exp_a ≥ exp_b: swap=0, d=diff[7:0].
  - Otherwise: swap=1, d=exp_b−exp_a.
  - Equal exponents give swap=0, whatever the mantissa values.
- Clamp: d_eff = min(d, MANT_W+2). Larger shifts give an identical result.
- Shift register loads {small_mant, 3'b000}, with rem = d_eff. The block registers exp_out, swap and mant_big.
- Next state after accept: d_eff=0 goes to DONE, otherwise to SHIFT.
- Each SHIFT cycle:
  - s = min(rem, STEP).
  - reg ← reg >> s, and the new bit 0 = OR of old reg[s:0] (sticky also absorbs every shifted-out bit).
  - rem ← rem − s.
  - When rem reaches 0, go to DONE.
- DONE: out_valid=1, and outputs stay stable until out_ready. out_valid && out_ready → IDLE.
- Exponent 0 or 255 gets no special handling. The upstream unpacker supplies effective exponents and hidden bits.
- rst asserted in any state returns the block to IDLE immediately and clears all outputs. An in-flight operation is lost.

## Timing
- Latency from the accept edge to the first cycle of out_valid is 1 + ceil(d_eff/STEP) cycles. d=0 gives 1 cycle.
- Throughput is one operation per (latency + 1) cycles at minimum: in_ready falls on accept and rises in the cycle after the handshake.
- in_ready and out_valid are never high in the same cycle.
- out_ready held low stalls DONE indefinitely with outputs unchanged.

## Configuration
- FP_ALIGN_FASTPATH_EN defined: when d ≥ MANT_W+2, the accept edge goes directly to DONE. mant_small = {MANT_W+2 zeros, |small_mant} and latency is 1.
- Undefined: such cases iterate through SHIFT with d_eff = MANT_W+2. The result is bit-identical and latency is 1 + ceil((MANT_W+2)/STEP).

## Structure
- Shared package fp_pkg holds:
  - FSM state enum (IDLE, SHIFT, DONE).
  - GRS_W = 3.
  - FP32 exponent width constant EXP_W = 8.
- Sub-module fp_sticky_shr: combinational right shift by 0..STEP with sticky fold into bit 0. It is instantiated once in the SHIFT datapath.

## Test plan
- exp_a=130, exp_b=127, mant_a=0xC00000, mant_b=0x800000 → swap=0, exp_out=130, mant_big=0xC00000, mant_small=27'h0800000, out_valid 2 cycles after accept.
- exp_a=100, exp_b=105, mant_a=0x800001, mant_b=0xA00000 → swap=1, exp_out=105, mant_big=0xA00000, mant_small=27'h0200001 (sticky set), latency 3.
- exp_a=exp_b=127, mant_a=0x800000, mant_b=0xFFFFFF → swap=0, mant_small=27'h7FFFFF8, latency 1.
- exp_a=200, exp_b=10, mant_b=0x800000 → mant_small=27'h0000001. Latency is 1 with FP_ALIGN_FASTPATH_EN and 8 without (STEP=4).
- Backpressure: out_ready low for 5 cycles in DONE → outputs stable, in_ready=0. A new in_valid is not accepted until the cycle after the handshake.
- rst pulsed during SHIFT (d=20) → same-cycle IDLE, out_valid=0, in_ready=1. The next operation completes correctly.
